// File: rtl/timer_apb_sequencer.sv
// timer_apb_sequencer: APB master that programs a timer_8bit slave, polls TSR for
// overflow/underflow, reports events, clears TSR and optionally re-arms.
module timer_apb_sequencer #(
  parameter int                    ADDR_WIDTH    = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 12'h000,
  parameter int                    POLL_INTERVAL = 16,
  parameter int                    MAX_POLLS     = 1024,
  parameter int                    POLL_W        = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [7:0]            cfg_tdr,
  input  logic [7:0]            cfg_tcr,
  input  logic                  cfg_repeat,
  output logic                  busy,
  output logic                  evt_ovf,
  output logic                  evt_udf,
  output logic                  done,
  output logic                  error,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [7:0]            pwdata,
  input  logic [7:0]            prdata,
  input  logic                  pready,
  input  logic                  pslverr
);
  typedef enum logic [2:0] {S_IDLE, S_WR_TDR, S_LOAD, S_RUN, S_WAIT, S_RD_TSR, S_CLR_TSR, S_HALT} state_t;
  state_t              r_state;
  logic [7:0]          r_tcr;
  logic                r_rep;
  logic                r_stop;
  logic [POLL_W-1:0]   r_ivl;
  logic [POLL_W-1:0]   r_polls;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]          w_wdata;
  logic                w_wr;
  logic                w_xfer;
  logic                w_stop;
  logic                w_timeout;
  logic                w_ivl_end;
  logic [1:0]          w_flags;
  logic [POLL_W-1:0]   w_polls_nxt;
  always_comb begin
    w_addr      = (r_state == S_WR_TDR) ? BASE_ADDR :
                  (r_state == S_RD_TSR || r_state == S_CLR_TSR) ? BASE_ADDR + ADDR_WIDTH'(2) :
                  BASE_ADDR + ADDR_WIDTH'(1);
    w_wdata     = (r_state == S_LOAD) ? (r_tcr | 8'h80) : (r_state == S_RUN) ? (r_tcr & 8'h7F) : 8'h00;
    w_wr        = r_state != S_RD_TSR;
    w_xfer      = r_state != S_IDLE && r_state != S_WAIT;
    w_stop      = stop | r_stop;
    w_flags     = prdata[1:0];
    w_polls_nxt = r_polls + 1'b1;
    w_timeout   = w_polls_nxt == POLL_W'(MAX_POLLS);
    w_ivl_end   = r_ivl == POLL_W'(POLL_INTERVAL - 1);
  end
  // Every transfer state after the first starts with one idle cycle, then SETUP, then ACCESS.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state <= S_IDLE;
      r_tcr   <= '0;
      r_rep   <= 1'b0;
      r_stop  <= 1'b0;
      r_ivl   <= '0;
      r_polls <= '0;
      busy    <= 1'b0;
      evt_ovf <= 1'b0;
      evt_udf <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      evt_ovf <= 1'b0;
      evt_udf <= 1'b0;
      done    <= 1'b0;
      r_ivl   <= '0;
      if (w_xfer && r_state != S_HALT && stop) r_stop <= 1'b1;
      case (r_state)
        S_IDLE: if (start) begin
          r_tcr   <= cfg_tcr;
          r_rep   <= cfg_repeat;
          r_stop  <= 1'b0;
          error   <= 1'b0;
          busy    <= 1'b1;
          psel    <= 1'b1;
          pwrite  <= 1'b1;
          paddr   <= BASE_ADDR;
          pwdata  <= cfg_tdr;
          r_state <= S_WR_TDR;
        end
        S_WAIT: begin
          r_ivl   <= w_ivl_end ? '0 : r_ivl + 1'b1;
          r_state <= stop ? S_HALT : w_ivl_end ? S_RD_TSR : S_WAIT;
        end
        default: begin
          if (!psel) begin
            psel   <= 1'b1;
            paddr  <= w_addr;
            pwdata <= w_wdata;
            pwrite <= w_wr;
          end else if (!penable) begin
            penable <= 1'b1;
          end else if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            r_stop  <= 1'b0;
            if (r_state == S_HALT) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              error   <= error | pslverr;
              r_state <= S_IDLE;
            end else if (pslverr) begin
              error   <= 1'b1;
              r_state <= S_HALT;
            end else begin
              case (r_state)
                S_WR_TDR: r_state <= w_stop ? S_HALT : S_LOAD;
                S_LOAD:   r_state <= w_stop ? S_HALT : S_RUN;
                S_RUN: begin
                  r_polls <= '0;
                  r_state <= w_stop ? S_HALT : S_WAIT;
                end
                S_RD_TSR: begin
                  r_polls <= w_polls_nxt;
                  evt_ovf <= w_flags[0];
                  evt_udf <= w_flags[1];
                  if (w_flags != 2'b00) r_state <= w_stop ? S_HALT : S_CLR_TSR;
                  else if (w_timeout) begin
                    error   <= 1'b1;
                    r_state <= S_HALT;
                  end else r_state <= w_stop ? S_HALT : S_WAIT;
                end
                S_CLR_TSR: begin
                  r_polls <= '0;
                  r_state <= (r_rep && !w_stop) ? S_WAIT : S_HALT;
                end
                default: r_state <= S_HALT;
              endcase
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_timer_apb_sequencer.sv
// tb_timer_apb_sequencer: randomized APB-slave bench with a transaction-level model of the sequencer.
module tb_timer_apb_sequencer;
  localparam int PI = 16;
  localparam int MP = 4;
  typedef logic [20:0] xfer_t;
  logic        pclk = 0, presetn = 0, start = 0, stop = 0, cfg_repeat = 0;
  logic [7:0]  cfg_tdr = 0, cfg_tcr = 0, prdata = 0;
  logic        pready = 0, pslverr = 0;
  logic        busy, evt_ovf, evt_udf, done, error, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [7:0]  pwdata;
  timer_apb_sequencer #(.ADDR_WIDTH(12), .BASE_ADDR(12'h000), .POLL_INTERVAL(PI), .MAX_POLLS(MP), .POLL_W(16)) dut (
    .pclk(pclk), .presetn(presetn), .start(start), .stop(stop), .cfg_tdr(cfg_tdr), .cfg_tcr(cfg_tcr),
    .cfg_repeat(cfg_repeat), .busy(busy), .evt_ovf(evt_ovf), .evt_udf(evt_udf), .done(done), .error(error),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr));
  always #5 pclk = ~pclk;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;
  xfer_t      got[$];
  int         len_q[$];
  logic [1:0] ev_q[$];
  logic [7:0] tsr_q[$];
  int         ws_q[$];
  int err_idx = -1, xidx = 0, ws_left = 0, pen_len = 0, prot_err = 0, done_cnt = 0, first_rd = -1;
  logic [1:0]  exp_evt = 0, m_nexp;
  logic [7:0]  m_rd;
  logic        p_psel = 0, p_pen = 0, p_rdy = 0, p_wr = 0;
  logic [11:0] p_addr = 0;
  logic [7:0]  p_wd = 0;
  // APB slave plus protocol/event-timing monitor, evaluated on the falling edge.
  always @(negedge pclk) begin
    if (!presetn) begin
      p_psel = 0; p_pen = 0; p_rdy = 0; exp_evt = 0; pready = 0; pslverr = 0; ws_left = 0; pen_len = 0;
    end else begin
      if (penable && !psel) prot_err++;
      if (penable && !p_psel) prot_err++;
      if (psel && !penable && p_psel) prot_err++;
      if (p_psel && !p_pen && !(psel && penable)) prot_err++;
      if (p_pen && p_rdy && psel) prot_err++;
      if (p_pen && !p_rdy && !(psel && penable)) prot_err++;
      if (p_psel && psel && !(p_pen && p_rdy) && (paddr !== p_addr || pwdata !== p_wd || pwrite !== p_wr)) prot_err++;
      if ({evt_udf, evt_ovf} !== exp_evt) prot_err++;
      if ({evt_udf, evt_ovf} != 2'b00) ev_q.push_back({evt_udf, evt_ovf});
      if (done) begin done_cnt++; if (busy) prot_err++; end
      pready = 0; pslverr = 0; m_nexp = 0; prdata = 8'($urandom);
      if (psel && !penable) begin
        ws_left = ws_q.size() > 0 ? ws_q.pop_front() : 0;
        pen_len = 0;
        if (!pwrite && first_rd < 0) first_rd = cyc;
      end
      if (psel && penable) begin
        pen_len++;
        if (ws_left > 0) ws_left--;
        else begin
          pready = 1;
          pslverr = (xidx == err_idx);
          m_rd = (!pwrite && tsr_q.size() > 0) ? tsr_q.pop_front() : {6'($urandom), 2'b00};
          if (!pwrite) prdata = m_rd;
          got.push_back({paddr, pwrite, pwrite ? pwdata : 8'h00});
          len_q.push_back(pen_len);
          if (!pwrite && !pslverr) m_nexp = m_rd[1:0];
          xidx++;
        end
      end
      exp_evt = m_nexp;
      p_psel = psel; p_pen = penable; p_rdy = pready; p_wr = pwrite; p_addr = paddr; p_wd = pwdata;
    end
  end
  function automatic xfer_t mk(input int a, input logic w, input logic [7:0] d);
    return {12'(a), w, d};
  endfunction
  task automatic prep();
    got.delete(); len_q.delete(); ev_q.delete(); tsr_q.delete(); ws_q.delete();
    xidx = 0; err_idx = -1; done_cnt = 0; first_rd = -1; prot_err = 0;
  endtask
  task automatic do_start(input logic [7:0] tdr, input logic [7:0] tcr, input logic rep, output int sc);
    @(negedge pclk);
    cfg_tdr = tdr; cfg_tcr = tcr; cfg_repeat = rep; start = 1; sc = cyc;
    @(negedge pclk);
    start = 0; cfg_tdr = 8'($urandom); cfg_tcr = 8'($urandom); cfg_repeat = 1'($urandom);
  endtask
  task automatic wait_done(input string nm);
    int n = 0;
    while (done_cnt == 0 && n < 20000) begin @(negedge pclk); n++; end
    repeat (3) @(negedge pclk);
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL %s_done count %0d required 1", nm, done_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %b required 0", nm, busy); end
    checks++;
    if (prot_err !== 0) begin errors++; $display("FAIL %s_protocol violations %0d required 0", nm, prot_err); end
  endtask
  task automatic test_reset();
    presetn = 0;
    repeat (2) @(negedge pclk);
    checks++;
    if ({psel, penable, pwrite, busy, error, done, evt_ovf, evt_udf, paddr, pwdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h required 0", {psel, penable, pwrite, busy, error, done, evt_ovf, evt_udf, paddr, pwdata});
    end
    presetn = 1;
  endtask
  task automatic test_single();
    for (int it = 0; it < 3; it++) begin
      xfer_t exp[$];
      logic [7:0] tdr, tcr;
      int k, sc;
      logic [1:0] f;
      tdr = it == 0 ? 8'hFF : 8'($urandom);
      tcr = it == 0 ? 8'h32 : 8'($urandom);
      k = $urandom_range(0, MP - 1);
      f = 2'($urandom_range(1, 3));
      prep();
      for (int i = 0; i < k; i++) tsr_q.push_back({6'($urandom), 2'b00});
      tsr_q.push_back({6'($urandom), f});
      do_start(tdr, tcr, 0, sc);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b required 1", busy); end
      cfg_tcr = ~tcr; cfg_tdr = ~tdr; start = 1;
      @(negedge pclk);
      start = 0;
      exp.push_back(mk(0, 1, tdr)); exp.push_back(mk(1, 1, tcr | 8'h80)); exp.push_back(mk(1, 1, tcr & 8'h7F));
      for (int i = 0; i <= k; i++) exp.push_back(mk(2, 0, 0));
      exp.push_back(mk(2, 1, 0)); exp.push_back(mk(1, 1, 0));
      wait_done("single");
      checks++;
      if (got.size() != exp.size()) begin errors++; $display("FAIL single_len got %0d required %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin errors++; $display("FAIL single_xfer[%0d] got %h required %h", i, got[i], exp[i]); end
      end
      checks++;
      if (ev_q.size() != 1 || ev_q[0] !== f) begin errors++; $display("FAIL single_evt count %0d required 1 flags %b", ev_q.size(), f); end
      checks++;
      if (first_rd !== sc + 9 + PI + 1) begin errors++; $display("FAIL single_latency got %0d required %0d", first_rd - sc, 9 + PI + 1); end
      checks++;
      if (error !== 1'b0) begin errors++; $display("FAIL single_error got %b required 0", error); end
    end
  endtask
  task automatic test_repeat();
    xfer_t exp[$];
    logic [1:0] fl[$];
    logic [7:0] tcr;
    int n, k, sc, target, w, sz;
    tcr = {2'b00, 1'b0, 1'b1, 2'($urandom), 2'($urandom)};
    n = $urandom_range(2, 3);
    prep();
    exp.push_back(mk(0, 1, 8'hF0)); exp.push_back(mk(1, 1, tcr | 8'h80)); exp.push_back(mk(1, 1, tcr & 8'h7F));
    for (int e = 0; e < n; e++) begin
      k = $urandom_range(0, MP - 1);
      fl.push_back(2'($urandom_range(1, 3)));
      for (int i = 0; i < k; i++) tsr_q.push_back({6'($urandom), 2'b00});
      tsr_q.push_back({6'($urandom), fl[e]});
      for (int i = 0; i <= k; i++) exp.push_back(mk(2, 0, 0));
      exp.push_back(mk(2, 1, 0));
    end
    target = exp.size();
    exp.push_back(mk(1, 1, 0));
    do_start(8'hF0, tcr, 1, sc);
    w = 0;
    while (got.size() < target && w < 5000) begin @(negedge pclk); w++; end
    checks++;
    if (got.size() < target) begin errors++; $display("FAIL repeat_progress got %0d required %0d", got.size(), target); end
    repeat (2) @(negedge pclk);
    stop = 1;
    @(negedge pclk);
    stop = 0;
    wait_done("repeat");
    sz = got.size();
    repeat (40) @(negedge pclk);
    checks++;
    if (got.size() != sz || psel !== 1'b0) begin errors++; $display("FAIL repeat_quiet got %0d transfers required %0d", got.size(), sz); end
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL repeat_len got %0d required %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL repeat_xfer[%0d] got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (ev_q.size() != n) begin errors++; $display("FAIL repeat_evt_count got %0d required %0d", ev_q.size(), n); end
    for (int i = 0; i < n && i < ev_q.size(); i++) begin
      checks++;
      if (ev_q[i] !== fl[i]) begin errors++; $display("FAIL repeat_evt[%0d] got %b required %b", i, ev_q[i], fl[i]); end
    end
  endtask
  task automatic test_wait_states();
    xfer_t exp[$];
    int ws[$];
    logic [7:0] tdr, tcr;
    int k, sc;
    tdr = 8'($urandom); tcr = 8'h32;
    k = $urandom_range(0, MP - 1);
    prep();
    for (int i = 0; i < k; i++) tsr_q.push_back(8'h00);
    tsr_q.push_back(8'h01);
    for (int i = 0; i < k + 6; i++) ws.push_back(i == 1 ? 5 : $urandom_range(0, 5));
    foreach (ws[i]) ws_q.push_back(ws[i]);
    exp.push_back(mk(0, 1, tdr)); exp.push_back(mk(1, 1, tcr | 8'h80)); exp.push_back(mk(1, 1, tcr & 8'h7F));
    for (int i = 0; i <= k; i++) exp.push_back(mk(2, 0, 0));
    exp.push_back(mk(2, 1, 0)); exp.push_back(mk(1, 1, 0));
    do_start(tdr, tcr, 0, sc);
    wait_done("waits");
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL waits_len got %0d required %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i] || len_q[i] !== ws[i] + 1) begin
        errors++; $display("FAIL waits_xfer[%0d] got %h/%0d required %h/%0d", i, got[i], len_q[i], exp[i], ws[i] + 1);
      end
    end
  endtask
  task automatic test_slverr();
    for (int idx = 0; idx < 4; idx++) begin
      xfer_t exp[$];
      logic [7:0] tdr, tcr;
      int sc;
      tdr = 8'($urandom); tcr = 8'($urandom);
      prep();
      tsr_q.push_back(8'h02);
      err_idx = idx < 3 ? idx : 5;
      exp.push_back(mk(0, 1, tdr)); exp.push_back(mk(1, 1, tcr | 8'h80)); exp.push_back(mk(1, 1, tcr & 8'h7F));
      if (idx < 3) exp = exp[0:idx];
      else begin exp.push_back(mk(2, 0, 0)); exp.push_back(mk(2, 1, 0)); end
      exp.push_back(mk(1, 1, 0));
      do_start(tdr, tcr, 0, sc);
      if (idx > 0) begin
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL slverr_clear got %b required 0", error); end
      end
      wait_done("slverr");
      checks++;
      if (error !== 1'b1) begin errors++; $display("FAIL slverr_error[%0d] got %b required 1", idx, error); end
      checks++;
      if (got.size() != exp.size()) begin errors++; $display("FAIL slverr_len[%0d] got %0d required %0d", idx, got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin errors++; $display("FAIL slverr_xfer[%0d][%0d] got %h required %h", idx, i, got[i], exp[i]); end
      end
    end
  endtask
  task automatic test_timeout();
    xfer_t exp[$];
    logic [7:0] tdr, tcr;
    int sc;
    tdr = 8'($urandom); tcr = 8'($urandom);
    prep();
    exp.push_back(mk(0, 1, tdr)); exp.push_back(mk(1, 1, tcr | 8'h80)); exp.push_back(mk(1, 1, tcr & 8'h7F));
    for (int i = 0; i < MP; i++) exp.push_back(mk(2, 0, 0));
    exp.push_back(mk(1, 1, 0));
    do_start(tdr, tcr, 1, sc);
    wait_done("timeout");
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL timeout_error got %b required 1", error); end
    checks++;
    if (ev_q.size() != 0) begin errors++; $display("FAIL timeout_evt got %0d required 0", ev_q.size()); end
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL timeout_len got %0d required %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL timeout_xfer[%0d] got %h required %h", i, got[i], exp[i]); end
    end
  endtask
  task automatic test_reset_mid();
    xfer_t exp[$];
    logic [7:0] tdr, tcr;
    int sc, w;
    prep();
    ws_q.push_back(0); ws_q.push_back(5);
    do_start(8'($urandom), 8'($urandom), 0, sc);
    w = 0;
    while (!(penable && paddr == 12'h001) && w < 50) begin @(negedge pclk); w++; end
    checks++;
    if (!penable) begin errors++; $display("FAIL rstmid_access got penable %b required 1", penable); end
    presetn = 0;
    @(negedge pclk);
    checks++;
    if ({psel, penable, busy, error} !== 4'b0000) begin errors++; $display("FAIL rstmid_outputs got %b required 0000", {psel, penable, busy, error}); end
    presetn = 1;
    prep();
    tdr = 8'($urandom); tcr = 8'($urandom);
    tsr_q.push_back(8'h03);
    exp.push_back(mk(0, 1, tdr)); exp.push_back(mk(1, 1, tcr | 8'h80)); exp.push_back(mk(1, 1, tcr & 8'h7F));
    exp.push_back(mk(2, 0, 0)); exp.push_back(mk(2, 1, 0)); exp.push_back(mk(1, 1, 0));
    do_start(tdr, tcr, 0, sc);
    checks++;
    if (!(psel && !penable && paddr == 12'h000 && pwdata == tdr)) begin
      errors++; $display("FAIL rstmid_restart got psel %b addr %h data %h required 1 000 %h", psel, paddr, pwdata, tdr);
    end
    wait_done("rstmid");
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL rstmid_len got %0d required %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL rstmid_xfer[%0d] got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (ev_q.size() != 1 || ev_q[0] !== 2'b11) begin errors++; $display("FAIL rstmid_evt count %0d required 1", ev_q.size()); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_wait_states();
    test_slverr();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
